// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths, pointer wrap helper and per-cycle operation
// encoding for the sync_fifo_buf family.
package sync_fifo_pkg;

  // Per-cycle accepted operation, ordered so that {write_ok, read_ok} casts directly.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Pointer width. Never returns zero, even for the smallest depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width. It must be able to hold the value DEPTH.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap, so non-power-of-2 depths work.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x D_WIDTH storage with one write port and one
// registered read port with read enable. The array is not reset. The read
// register is reset, so the FIFO output reads zero after reset.
// Ports: i_clk, i_rst (sync, active-high, read register only),
//        i_we/i_waddr/i_wdata write port, i_re/i_raddr read request,
//        o_rdata registered read data (holds its value when i_re=0).
module sync_fifo_ram #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [D_WIDTH-1:0] i_wdata,
  input  logic               i_re,
  input  logic [AW-1:0]      i_raddr,
  output logic [D_WIDTH-1:0] o_rdata
);

  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [D_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with any depth >= 2. It provides an
// occupancy count, almost-full and almost-empty thresholds, a registered read
// port, and sticky overflow and underflow flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through.
// In that mode the head word is prefetched into the read register.
// Ports: clk, rst (sync, active-high); winc/wdata write request;
//        wfull, walmost_full; rinc read request (pop in FWFT); rdata, rvalid;
//        rempty, ralmost_empty; count (0..DEPTH); overflow, underflow (sticky).
module sync_fifo_buf
  import sync_fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH  = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       winc,
  input  logic [D_WIDTH-1:0]         wdata,
  output logic                       wfull,
  output logic                       walmost_full,
  input  logic                       rinc,
  output logic [D_WIDTH-1:0]         rdata,
  output logic                       rvalid,
  output logic                       rempty,
  output logic                       ralmost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rvalid, r_overflow, r_underflow;

  logic     w_wr_ok, w_rd_ok, w_ram_re, w_rempty, w_rvalid_nxt;
  fifo_op_e w_op;

  assign wfull   = (r_count == FULL_C);
  assign w_wr_ok = winc && !wfull;

`ifdef SYNC_FIFO_FWFT_EN
  // In this mode, count includes the word held in the read register.
  // The RAM therefore holds count - rvalid words.
  // The head is refilled when the register is empty or is being popped.
  logic [CNT_W-1:0] w_ram_cnt;
  assign w_ram_cnt    = r_count - CNT_W'(r_rvalid);
  assign w_rempty     = !r_rvalid;
  assign w_rd_ok      = rinc && r_rvalid;
  assign w_ram_re     = (w_ram_cnt != '0) && (!r_rvalid || w_rd_ok);
  assign w_rvalid_nxt = w_ram_re || (r_rvalid && !w_rd_ok);
`else
  assign w_rempty     = (r_count == '0);
  assign w_rd_ok      = rinc && !w_rempty;
  assign w_ram_re     = w_rd_ok;
  assign w_rvalid_nxt = w_rd_ok;
`endif

  assign w_op = fifo_op_e'({w_wr_ok, w_rd_ok});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok)  r_wptr <= PTR_W'(ptr_next(32'(r_wptr), DEPTH));
      if (w_ram_re) r_rptr <= PTR_W'(ptr_next(32'(r_rptr), DEPTH));
      case (w_op)
        OP_WR:   r_count <= r_count + CNT_W'(1);
        OP_RD:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_rvalid <= w_rvalid_nxt;
      if (winc && wfull)    r_overflow  <= 1'b1;
      if (rinc && w_rempty) r_underflow <= 1'b1;
    end
  end

  sync_fifo_ram #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH),
    .AW      (PTR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr),
    .i_wdata (wdata),
    .i_re    (w_ram_re),
    .i_raddr (r_rptr),
    .o_rdata (rdata)
  );

  assign rvalid        = r_rvalid;
  assign rempty        = w_rempty;
  assign count         = r_count;
  assign walmost_full  = (r_count >= AF_C);
  assign ralmost_empty = (r_count <= AE_C);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule
